// File: rtl/axi_regfile_v2_if.sv
// AXI4-Lite channel bundle for axi_regfile_v2.
interface axi_regfile_v2_if #(
    parameter int unsigned ADDR_W = 6
);
    logic [ADDR_W-1:0] awaddr;
    logic [2:0]        awprot;
    logic              awvalid;
    logic              awready;
    logic [31:0]       wdata;
    logic [3:0]        wstrb;
    logic              wvalid;
    logic              wready;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready;
    logic [ADDR_W-1:0] araddr;
    logic [2:0]        arprot;
    logic              arvalid;
    logic              arready;
    logic [31:0]       rdata;
    logic [1:0]        rresp;
    logic              rvalid;
    logic              rready;

    modport master (
        output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        output araddr, arprot, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        input  araddr, arprot, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axi_regfile_v2.sv
// AXI4-Lite slave register file: byte-strobe writes, per-register reset values,
// self-clearing registers, write/read strobes. AXI_REGFILE_SLVERR_EN makes out-of-range accesses return SLVERR.
module axi_regfile_v2 #(
    parameter int unsigned             NREGS     = 16,
    parameter int unsigned             ADDR_W    = 6,
    parameter logic [NREGS*32-1:0]     RESET_VAL = '0,
    parameter logic [NREGS-1:0]        SC_MASK   = '0
) (
    input  logic                  S_AXI_ACLK,
    input  logic                  S_AXI_ARESETN,
    axi_regfile_v2_if.slave       s_axi,
    output logic [NREGS*32-1:0]   slv_reg,
    input  logic [NREGS*32-1:0]   slv_read,
    output logic [NREGS-1:0]      wr_pulse,
    output logic [NREGS-1:0]      rd_pulse
);
    localparam int unsigned IDX_W     = ADDR_W - 2;
    localparam logic [1:0]  RESP_OKAY = 2'b00;
`ifdef AXI_REGFILE_SLVERR_EN
    localparam logic [1:0]  RESP_OOR  = 2'b10;
`else
    localparam logic [1:0]  RESP_OOR  = 2'b00;
`endif

    logic              aw_held, aw_held_n, w_held, w_held_n;
    logic [IDX_W-1:0]  aw_idx, aw_idx_n;
    logic [31:0]       w_data, w_data_n;
    logic [3:0]        w_strb, w_strb_n;
    logic              awready_n, wready_n, bvalid_n, arready_n, rvalid_n;
    logic [1:0]        bresp_n, rresp_n;
    logic [31:0]       rdata_n, rd_word_c;
    logic [NREGS*32-1:0] slv_reg_n;
    logic [NREGS-1:0]  wr_pulse_n, rd_pulse_n;
    logic              aw_hs_c, w_hs_c, ar_hs_c, aw_in_range_c, ar_in_range_c;
    logic [IDX_W-1:0]  ar_idx_c;
    logic              unused;

    assign unused        = ^{s_axi.awprot, s_axi.arprot, s_axi.awaddr[1:0], s_axi.araddr[1:0]};
    assign aw_hs_c       = s_axi.awvalid && s_axi.awready;
    assign w_hs_c        = s_axi.wvalid && s_axi.wready;
    assign ar_hs_c       = s_axi.arvalid && s_axi.arready;
    assign ar_idx_c      = s_axi.araddr[ADDR_W-1:2];
    assign aw_in_range_c = 32'(aw_idx) < NREGS;
    assign ar_in_range_c = 32'(ar_idx_c) < NREGS;

    // Read mux; out-of-range indices fall through to zero
    always_comb begin
        rd_word_c = '0;
        for (int unsigned i = 0; i < NREGS; i++) begin
            if (32'(ar_idx_c) == i) rd_word_c = slv_read[32*i +: 32];
        end
    end

    // Next-state for both channels and the register array
    always_comb begin
        aw_held_n  = aw_held;
        w_held_n   = w_held;
        aw_idx_n   = aw_idx;
        w_data_n   = w_data;
        w_strb_n   = w_strb;
        bvalid_n   = s_axi.bvalid;
        bresp_n    = s_axi.bresp;
        rvalid_n   = s_axi.rvalid;
        rdata_n    = s_axi.rdata;
        rresp_n    = s_axi.rresp;
        slv_reg_n  = slv_reg;
        wr_pulse_n = '0;
        rd_pulse_n = '0;

        // A self-clearing register was written last cycle: restore it unless overwritten below
        for (int unsigned i = 0; i < NREGS; i++) begin
            if (SC_MASK[i] && wr_pulse[i]) slv_reg_n[32*i +: 32] = RESET_VAL[32*i +: 32];
        end

        if (aw_hs_c) begin
            aw_held_n = 1'b1;
            aw_idx_n  = s_axi.awaddr[ADDR_W-1:2];
        end
        if (w_hs_c) begin
            w_held_n = 1'b1;
            w_data_n = s_axi.wdata;
            w_strb_n = s_axi.wstrb;
        end
        if (s_axi.bvalid && s_axi.bready) bvalid_n = 1'b0;

        if (aw_held && w_held) begin
            aw_held_n = 1'b0;
            w_held_n  = 1'b0;
            bvalid_n  = 1'b1;
            bresp_n   = aw_in_range_c ? RESP_OKAY : RESP_OOR;
            for (int unsigned i = 0; i < NREGS; i++) begin
                if (32'(aw_idx) == i) begin
                    wr_pulse_n[i] = 1'b1;
                    for (int unsigned b = 0; b < 4; b++) begin
                        if (w_strb[b]) slv_reg_n[32*i + 8*b +: 8] = w_data[8*b +: 8];
                    end
                end
            end
        end

        if (s_axi.rvalid && s_axi.rready) rvalid_n = 1'b0;
        if (ar_hs_c) begin
            rvalid_n = 1'b1;
            rdata_n  = rd_word_c;
            rresp_n  = ar_in_range_c ? RESP_OKAY : RESP_OOR;
            for (int unsigned i = 0; i < NREGS; i++) begin
                if (32'(ar_idx_c) == i) rd_pulse_n[i] = 1'b1;
            end
        end

        awready_n = !aw_held_n && !bvalid_n;
        wready_n  = !w_held_n && !bvalid_n;
        arready_n = !rvalid_n;
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            aw_held       <= 1'b0;
            w_held        <= 1'b0;
            aw_idx        <= '0;
            w_data        <= '0;
            w_strb        <= '0;
            s_axi.awready <= 1'b1;
            s_axi.wready  <= 1'b1;
            s_axi.bvalid  <= 1'b0;
            s_axi.bresp   <= RESP_OKAY;
            s_axi.arready <= 1'b1;
            s_axi.rvalid  <= 1'b0;
            s_axi.rdata   <= '0;
            s_axi.rresp   <= RESP_OKAY;
            slv_reg       <= RESET_VAL;
            wr_pulse      <= '0;
            rd_pulse      <= '0;
        end else begin
            aw_held       <= aw_held_n;
            w_held        <= w_held_n;
            aw_idx        <= aw_idx_n;
            w_data        <= w_data_n;
            w_strb        <= w_strb_n;
            s_axi.awready <= awready_n;
            s_axi.wready  <= wready_n;
            s_axi.bvalid  <= bvalid_n;
            s_axi.bresp   <= bresp_n;
            s_axi.arready <= arready_n;
            s_axi.rvalid  <= rvalid_n;
            s_axi.rdata   <= rdata_n;
            s_axi.rresp   <= rresp_n;
            slv_reg       <= slv_reg_n;
            wr_pulse      <= wr_pulse_n;
            rd_pulse      <= rd_pulse_n;
        end
    end
endmodule
